// File: rtl/ppfifo_stream_writer.sv
// Stream-to-ping-pong-FIFO writer feeding the DDR3 input DMA.
// Packs valid/ready words into buffers, releases on full/idle/end.
module ppfifo_stream_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 24,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic                   o_finished,
  output logic                   o_busy,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [1:0]             i_wr_ready,
  output logic [1:0]             o_wr_activate,
  input  logic [COUNT_WIDTH-1:0] i_wr_size,
  output logic                   o_wr_stb,
  output logic [DATA_WIDTH-1:0]  o_wr_data
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRAB,
    FILL,
    RELEASE,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [COUNT_WIDTH-1:0] remaining;
  logic [COUNT_WIDTH-1:0] word_cnt;
  logic [TW-1:0]          tmo;
  logic                   full;
  logic                   accept;
  logic                   expired;
  logic                   leave;

  assign full    = word_cnt >= i_wr_size;
  assign o_ready = (state == FILL) && !full &&
                   (remaining != '0) && i_enable;
  assign accept  = o_ready && i_valid;

  // Expiry is flagged one count early so the buffer drops
  // exactly IDLE_TIMEOUT edges after the last accepted word.
  assign expired = (word_cnt != '0) &&
                   (tmo == TW'(IDLE_TIMEOUT - 1));

  // An accept this cycle means a strobe is still owed, so stay.
  assign leave = !accept &&
                 (full || (remaining == '0) ||
                  expired || !i_enable);

  assign o_busy     = (state == GRAB) || (state == FILL) ||
                      (state == RELEASE);
  assign o_finished = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (i_enable)
          state_n = (i_count != '0) ? GRAB : DONE;
      end
      GRAB: begin
        if (!i_enable)              state_n = IDLE;
        else if (i_wr_ready != '0)  state_n = FILL;
      end
      FILL: begin
        if (leave) state_n = RELEASE;
      end
      RELEASE: begin
        if (remaining == '0) state_n = DONE;
        else if (!i_enable)  state_n = IDLE;
        else                 state_n = GRAB;
      end
      DONE: begin
        if (!i_enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters, buffer ownership and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining     <= '0;
      word_cnt      <= '0;
      tmo           <= '0;
      o_wr_activate <= 2'b00;
      o_wr_stb      <= 1'b0;
      o_wr_data     <= '0;
    end else begin
      o_wr_stb <= 1'b0;
      if (accept) begin
        o_wr_stb  <= 1'b1;
        o_wr_data <= i_data;
        word_cnt  <= word_cnt + 1'b1;
        remaining <= remaining - 1'b1;
        tmo       <= '0;
      end else if ((state == FILL) && (word_cnt != '0) &&
                   (tmo != TW'(IDLE_TIMEOUT))) begin
        tmo <= tmo + 1'b1;
      end
      if ((state == IDLE) && i_enable && (i_count != '0))
        remaining <= i_count;
      if ((state == GRAB) && i_enable &&
          (i_wr_ready != '0)) begin
        o_wr_activate <= i_wr_ready[0] ? 2'b01 : 2'b10;
        word_cnt      <= '0;
        tmo           <= '0;
      end
      if ((state == FILL) && leave)
        o_wr_activate <= 2'b00;
    end
  end

endmodule

// File: tb/tb_ppfifo_stream_writer.sv
// Bench for ppfifo_stream_writer: random stream source, a
// ping-pong FIFO model and chunk/order reference checks.
module tb_ppfifo_stream_writer;

  localparam int DW = 32;
  localparam int CW = 24;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic [CW-1:0] i_count;
  logic          o_finished;
  logic          o_busy;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_wr_ready;
  logic [1:0]    o_wr_activate;
  logic [CW-1:0] i_wr_size;
  logic          o_wr_stb;
  logic [DW-1:0] o_wr_data;

  always #5 clk = ~clk;

  ppfifo_stream_writer #(
    .DATA_WIDTH(DW),
    .COUNT_WIDTH(CW),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_enable(i_enable),
    .i_count(i_count),
    .o_finished(o_finished),
    .o_busy(o_busy),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_wr_ready(i_wr_ready),
    .o_wr_activate(o_wr_activate),
    .i_wr_size(i_wr_size),
    .o_wr_stb(o_wr_stb),
    .o_wr_data(o_wr_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0]  act_q = 2'b00;
  logic [1:0]  rdy_q;
  bit          fifo_auto;
  int          rel_t [2];
  int          cur_n;
  int          cur_side;
  int          bufs [$];
  int          sides [$];
  int          szl [$];
  int          sz_def;
  logic [31:0] sent [$];
  logic [31:0] got [$];
  int          rises;
  int          acc_cyc;
  int          fall_cyc;
  int          bad;
  logic [31:0] nxt;
  bit          seq;
  bit          src_on;
  int          pval;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock: capture the accept decision before the edge,
  // then observe outputs and advance the FIFO/source models.
  task automatic cycle();
    logic        acc;
    logic [31:0] w;
    #1;
    acc   = o_ready && i_valid;
    w     = i_data;
    rdy_q = i_wr_ready;
    if (o_ready && o_wr_activate == 2'b00) bad++;
    @(negedge clk);
    cyc++;
    if (acc) begin
      sent.push_back(w);
      acc_cyc = cyc;
      nxt = seq ? nxt + 1 : $urandom;
    end
    if (acc || o_wr_stb) chk("stb_latency", o_wr_stb, acc);
    if (acc) chk("stb_data", o_wr_data, w);
    if (o_wr_activate == 2'b11) bad++;
    if (act_q == 2'b00 && o_wr_activate != 2'b00) begin
      rises++;
      chk("act_side", o_wr_activate,
          rdy_q[0] ? 2'b01 : 2'b10);
      cur_side = o_wr_activate[1] ? 1 : 0;
      cur_n = 0;
      i_wr_ready[cur_side] = 1'b0;
      i_wr_size = CW'(szl.size() ? szl.pop_front() : sz_def);
      sides.push_back(cur_side);
    end
    if (o_wr_stb) begin
      got.push_back(o_wr_data);
      cur_n++;
      if (o_wr_activate == 2'b00) bad++;
    end
    if (act_q != 2'b00 && o_wr_activate == 2'b00) begin
      bufs.push_back(cur_n);
      fall_cyc = cyc;
      rel_t[cur_side] = 4;
    end
    for (int s = 0; s < 2; s++) begin
      if (rel_t[s] > 0) begin
        rel_t[s]--;
        if (rel_t[s] == 0 && fifo_auto) i_wr_ready[s] = 1'b1;
      end
    end
    act_q   = o_wr_activate;
    i_data  = nxt;
    i_valid = src_on && ($urandom_range(99) < pval);
  endtask

  task automatic clear(input int sz, input logic [1:0] rdy,
                       input bit aut);
    sent.delete(); got.delete(); bufs.delete();
    sides.delete(); szl.delete();
    rises = 0; bad = 0; rel_t[0] = 0; rel_t[1] = 0;
    sz_def = sz; i_wr_size = CW'(sz);
    i_wr_ready = rdy; fifo_auto = aut;
  endtask

  // Full transfer checked against size chunks and word order.
  task automatic run_xfer(input string tag, input int n,
                          input int pv);
    int exp_b [$];
    int tmp [$];
    int left;
    int s;
    int mism;
    tmp = szl;
    left = n;
    while (left > 0) begin
      s = tmp.size() ? tmp.pop_front() : sz_def;
      s = (s < left) ? s : left;
      exp_b.push_back(s);
      left -= s;
    end
    i_count = CW'(n); i_enable = 1'b1;
    src_on = 1'b1; pval = pv;
    for (int t = 0; t < 3000 && !o_finished; t++) cycle();
    chk({tag, "_finished"}, o_finished, 1'b1);
    chk({tag, "_act_idle"}, o_wr_activate, 2'b00);
    chk({tag, "_nsent"}, sent.size(), n);
    chk({tag, "_ngot"}, got.size(), n);
    mism = 0;
    for (int i = 0; i < got.size() && i < sent.size(); i++)
      if (got[i] !== sent[i]) mism++;
    chk({tag, "_order"}, mism, 0);
    chk({tag, "_nbufs"}, bufs.size(), exp_b.size());
    mism = 0;
    for (int i = 0; i < bufs.size() && i < exp_b.size(); i++)
      if (bufs[i] != exp_b[i]) mism++;
    chk({tag, "_chunks"}, mism, 0);
    chk({tag, "_protocol"}, bad, 0);
    i_enable = 1'b0; src_on = 1'b0; i_valid = 1'b0;
    cycle();
    chk({tag, "_fin_clear"}, o_finished, 1'b0);
    chk({tag, "_idle"}, o_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b0; i_count = '0;
    i_data = '0; i_valid = 1'b0; i_wr_ready = 2'b00;
    i_wr_size = '0; src_on = 1'b0; pval = 100;
    seq = 1'b1; nxt = 32'h0;
    clear(8, 2'b00, 1'b0);
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_finished", o_finished, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_act", o_wr_activate, 2'b00);
    chk("rst_stb", o_wr_stb, 1'b0);
    chk("rst_data", o_wr_data, 32'h0);

    // Single buffer, 0x100..0x107.
    clear(8, 2'b01, 1'b0);
    seq = 1'b1; nxt = 32'h100; i_data = nxt;
    run_xfer("single", 8, 100);
    chk("single_side", sides.size() ? sides[0] : -1, 0);
    chk("single_first", got.size() ? got[0] : 0, 32'h100);
    chk("single_last", got.size() ? got[$] : 0, 32'h107);

    // Ping-pong 20 words over 8-word buffers.
    clear(8, 2'b11, 1'b1);
    nxt = 32'h0; i_data = nxt;
    run_xfer("pingpong", 20, 100);
    chk("pp_nsides", sides.size(), 3);
    if (sides.size() == 3) begin
      chk("pp_side0", sides[0], 0);
      chk("pp_side1", sides[1], 1);
      chk("pp_side2", sides[2], 0);
    end
    chk("pp_last", got.size() ? got[$] : 0, 32'd19);

    // Randomized lengths, sizes and valid gaps.
    seq = 1'b0;
    for (int r = 0; r < 4; r++) begin
      clear($urandom_range(12, 1), 2'b11, 1'b1);
      run_xfer("random", $urandom_range(40, 1), 70);
    end

    // Idle timeout.
    clear(64, 2'b01, 1'b0);
    i_count = CW'(100); i_enable = 1'b1;
    src_on = 1'b0; i_valid = 1'b0;
    repeat (30) cycle();
    chk("to_empty_held", o_wr_activate, 2'b01);
    chk("to_empty_nbufs", bufs.size(), 0);
    src_on = 1'b1; pval = 100;
    for (int t = 0; t < 50 && sent.size() < 5; t++) cycle();
    src_on = 1'b0; i_valid = 1'b0;
    chk("to_nsent", sent.size(), 5);
    for (int t = 0; t < 100 && bufs.size() == 0; t++) cycle();
    chk("to_nbufs", bufs.size(), 1);
    chk("to_delay", fall_cyc - acc_cyc, TO);
    chk("to_strobes", bufs.size() ? bufs[0] : -1, 5);
    cycle();
    chk("to_regrab_busy", o_busy, 1'b1);
    chk("to_regrab_wait", o_wr_activate, 2'b00);
    i_wr_ready = 2'b10;
    cycle();
    chk("to_regrab_act", o_wr_activate, 2'b10);
    i_enable = 1'b0;
    for (int t = 0; t < 20 && o_busy; t++) cycle();
    chk("to_abort_idle", o_busy, 1'b0);
    chk("to_abort_fin", o_finished, 1'b0);

    // Backpressure: no buffer available.
    clear(8, 2'b00, 1'b0);
    i_count = CW'(4); i_enable = 1'b1;
    src_on = 1'b1; pval = 100;
    bad = 0;
    for (int t = 0; t < 50; t++) begin
      cycle();
      if (o_ready || o_wr_activate != 2'b00) bad++;
    end
    chk("bp_quiet", bad, 0);
    chk("bp_busy", o_busy, 1'b1);
    i_wr_ready = 2'b10;
    cycle();
    chk("bp_act", o_wr_activate, 2'b10);
    for (int t = 0; t < 100 && !o_finished; t++) cycle();
    chk("bp_finished", o_finished, 1'b1);
    chk("bp_ngot", got.size(), 4);
    i_enable = 1'b0; src_on = 1'b0; i_valid = 1'b0;
    cycle();

    // Abort after 3 of 10 words.
    clear(16, 2'b01, 1'b0);
    i_count = CW'(10); i_enable = 1'b1;
    src_on = 1'b1; pval = 100;
    for (int t = 0; t < 50 && sent.size() < 3; t++) cycle();
    i_enable = 1'b0; src_on = 1'b0; i_valid = 1'b0;
    for (int t = 0; t < 50 && o_busy; t++) cycle();
    chk("abort_idle", o_busy, 1'b0);
    chk("abort_fin", o_finished, 1'b0);
    chk("abort_act", o_wr_activate, 2'b00);
    chk("abort_ngot", got.size(), 3);
    chk("abort_buf", bufs.size() ? bufs[0] : -1, 3);
    chk("abort_protocol", bad, 0);

    // Reset in the middle of a fill.
    clear(16, 2'b01, 1'b0);
    i_count = CW'(10); i_enable = 1'b1;
    src_on = 1'b1; pval = 100;
    for (int t = 0; t < 50 && sent.size() < 4; t++) cycle();
    rst = 1'b1; src_on = 1'b0; i_valid = 1'b0;
    cycle();
    rst = 1'b0; i_enable = 1'b0;
    chk("mrst_finished", o_finished, 1'b0);
    chk("mrst_busy", o_busy, 1'b0);
    chk("mrst_ready", o_ready, 1'b0);
    chk("mrst_act", o_wr_activate, 2'b00);
    chk("mrst_stb", o_wr_stb, 1'b0);
    chk("mrst_data", o_wr_data, 32'h0);
    cycle();

    // Zero count.
    clear(8, 2'b11, 1'b0);
    i_count = '0; i_enable = 1'b1;
    cycle(); cycle();
    chk("zc_finished", o_finished, 1'b1);
    chk("zc_rises", rises, 0);
    chk("zc_busy", o_busy, 1'b0);
    i_enable = 1'b0;
    cycle();
    chk("zc_clear", o_finished, 1'b0);

    // Zero-size buffer followed by a normal one.
    clear(8, 2'b11, 1'b1);
    szl.push_back(0);
    run_xfer("zsize", 5, 100);
    chk("zsize_rises", rises, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
